leg_fetch_decode: RTL and testbench



---
 rtl/leg_pkg.sv | 35 +++
 rtl/leg_fetch_decode.sv | 116 +++++++++++
 tb/tb_leg_fetch_decode.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/leg_pkg.sv
// Shared definitions for the fetch/decode stage, register group and condition unit.
package leg_pkg;

    // Fetch/decode sequencer states: four byte fetches then one execute cycle.
    typedef enum logic [2:0] {
        F_OP  = 3'd0,
        F_A1  = 3'd1,
        F_A2  = 3'd2,
        F_DST = 3'd3,
        EXEC  = 3'd4
    } state_e;

    localparam int PC_STEP     = 4;
    localparam int INSTR_BYTES = 4;

    // Opcode bit positions (defaults shared with downstream blocks).
    localparam int COND_BIT_DEF = 5;
    localparam int IMM1_BIT_DEF = 7;
    localparam int IMM2_BIT_DEF = 6;

    // Byte offset within the instruction fetched in a given state.
    function automatic logic [7:0] fetch_idx(input state_e s);
        logic [7:0] idx;
        idx = 8'd0;
        case (s)
            F_OP:    idx = 8'd0;
            F_A1:    idx = 8'd1;
            F_A2:    idx = 8'd2;
            F_DST:   idx = 8'(INSTR_BYTES - 1);
            default: idx = 8'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/leg_fetch_decode.sv
// Instruction fetch/decode: pulls 4 bytes per instruction from byte-wide
// memory, presents register addresses, and resolves conditional jumps.
module leg_fetch_decode
    import leg_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'd0,
    parameter int         COND_BIT = COND_BIT_DEF,
    parameter int         IMM1_BIT = IMM1_BIT_DEF,
    parameter int         IMM2_BIT = IMM2_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic [7:0] mem_data,
    input  logic       mem_valid,
    input  logic       branch_taken,
    output logic [7:0] pc,
    output logic [7:0] opcode,
    output logic [7:0] out_addr1,
    output logic [7:0] out_addr2,
    output logic [7:0] in_addr,
    output logic       imm1,
    output logic       imm2,
    output logic       en_in,
    output logic       instr_valid
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] op_q, op_d;
    logic [7:0] a1_q, a1_d;
    logic [7:0] a2_q, a2_d;
    logic [7:0] dst_q, dst_d;

    // State and byte registers; reset discards any partially fetched instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= F_OP;
            pc_q    <= RESET_PC;
            op_q    <= 8'd0;
            a1_q    <= 8'd0;
            a2_q    <= 8'd0;
            dst_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            dst_q   <= dst_d;
        end
    end

    // Next state: advance on each accepted byte, resolve the PC in EXEC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        dst_d   = dst_q;
        case (state_q)
            F_OP: if (mem_valid) begin
                op_d    = mem_data;
                state_d = F_A1;
            end
            F_A1: if (mem_valid) begin
                a1_d    = mem_data;
                state_d = F_A2;
            end
            F_A2: if (mem_valid) begin
                a2_d    = mem_data;
                state_d = F_DST;
            end
            F_DST: if (mem_valid) begin
                dst_d   = mem_data;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = F_OP;
                // Jump targets are taken unaligned; sequential flow wraps at 256.
                if (op_q[COND_BIT] && branch_taken)
                    pc_d = dst_q;
                else
                    pc_d = pc_q + 8'(PC_STEP);
            end
            default: state_d = F_OP;
        endcase
    end

    // Outputs: request/valid strobes are suppressed while reset is asserted.
    always_comb begin
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        en_in       = 1'b0;
        mem_addr    = pc_q + fetch_idx(state_q);
        case (state_q)
            F_OP, F_A1, F_A2, F_DST: mem_req = ~rst;
            EXEC: begin
                instr_valid = ~rst;
                en_in       = ~rst & ~op_q[COND_BIT];
            end
            default: ;
        endcase
    end

    assign pc        = pc_q;
    assign opcode    = op_q;
    assign out_addr1 = a1_q;
    assign out_addr2 = a2_q;
    assign in_addr   = dst_q;
    assign imm1      = op_q[IMM1_BIT];
    assign imm2      = op_q[IMM2_BIT];

endmodule

// File: tb/tb_leg_fetch_decode.sv
// Scoreboard bench for leg_fetch_decode: program memory model, expected
// fetch-address and instruction queues, and a negedge monitor.
module tb_leg_fetch_decode;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic [7:0] mem_data;
    logic       mem_valid;
    logic       branch_taken;
    logic [7:0] pc, opcode, out_addr1, out_addr2, in_addr;
    logic       imm1, imm2, en_in, instr_valid;

    leg_fetch_decode dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_data(mem_data), .mem_valid(mem_valid),
        .branch_taken(branch_taken),
        .pc(pc), .opcode(opcode),
        .out_addr1(out_addr1), .out_addr2(out_addr2), .in_addr(in_addr),
        .imm1(imm1), .imm2(imm2), .en_in(en_in), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pc, op, a1, a2, dst;
        logic       en, i1, i2;
        logic [7:0] gap;
    } instr_t;

    logic [7:0] mem    [256];
    logic       bt_mem [256];
    logic [7:0] fexp_q [$];
    instr_t     iexp_q [$];

    int errors = 0;
    int checks = 0;
    int n_instr = 0;
    int gap_cnt = 0;
    int stall_left = 3;
    logic force_valid = 1'b0;

    // Memory model: zero-wait except three stall cycles on address 8'h06.
    always_comb begin
        mem_data  = mem[mem_addr];
        mem_valid = force_valid | (mem_req & ~((mem_addr == 8'h06) && (stall_left != 0)));
        branch_taken = bt_mem[pc];
    end

    always @(posedge clk)
        if (mem_req && mem_addr == 8'h06 && stall_left != 0) stall_left <= stall_left - 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_instr(input logic [7:0] p, op, a1, a2, dst,
                              input logic bt, en, i1, i2, input logic [7:0] gap);
        instr_t e;
        mem[p] = op; mem[8'(p + 8'd1)] = a1; mem[8'(p + 8'd2)] = a2; mem[8'(p + 8'd3)] = dst;
        bt_mem[p] = bt;
        for (int k = 0; k < 4; k++) fexp_q.push_back(8'(p + 8'(k)));
        e = '{pc: p, op: op, a1: a1, a2: a2, dst: dst, en: en, i1: i1, i2: i2, gap: gap};
        iexp_q.push_back(e);
    endtask

    // Monitor: compare every presented fetch and every EXEC cycle against the queues.
    always @(negedge clk) begin
        instr_t e;
        if (rst) begin
            gap_cnt = 0;
        end else begin
            gap_cnt++;
            if (mem_req) begin
                if (fexp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fetch: got addr %0h expected no request", mem_addr);
                end else if (mem_valid) begin
                    chk("fetch_addr", 32'(mem_addr), 32'(fexp_q.pop_front()));
                end else begin
                    chk("stall_addr", 32'(mem_addr), 32'(fexp_q[0]));
                end
            end
            if (instr_valid) begin
                if (iexp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_exec: got pc %0h expected no instruction", pc);
                end else begin
                    e = iexp_q.pop_front();
                    chk("exec_pc",   32'(pc),        32'(e.pc));
                    chk("exec_op",   32'(opcode),    32'(e.op));
                    chk("exec_a1",   32'(out_addr1), 32'(e.a1));
                    chk("exec_a2",   32'(out_addr2), 32'(e.a2));
                    chk("exec_dst",  32'(in_addr),   32'(e.dst));
                    chk("exec_en",   32'(en_in),     32'(e.en));
                    chk("exec_imm1", 32'(imm1),      32'(e.i1));
                    chk("exec_imm2", 32'(imm2),      32'(e.i2));
                    chk("exec_gap",  32'(gap_cnt),   32'(e.gap));
                end
                gap_cnt = 0;
                n_instr++;
            end else begin
                chk("en_idle", 32'(en_in), 32'(0));
            end
        end
    end

    task automatic wait_instr(input int n, output bit ok);
        int i;
        for (i = 0; i < 400 && n_instr < n; i++) @(posedge clk) #1;
        ok = (n_instr >= n);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL timeout_instr: got %0d expected %0d", n_instr, n);
        end
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; bt_mem[i] = 1'b0; end

        // pc, op, a1, a2, dst, bt, en, imm1, imm2, gap
        push_instr(8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        push_instr(8'h04, 8'h00, 8'h05, 8'h06, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8);
        push_instr(8'h08, 8'h20, 8'h11, 8'h12, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        push_instr(8'h40, 8'h20, 8'h21, 8'h22, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        push_instr(8'h44, 8'hC0, 8'h33, 8'h44, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
        push_instr(8'h48, 8'h40, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5);
        push_instr(8'h4C, 8'h20, 8'h00, 8'h00, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        push_instr(8'hFC, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
        // Aborted instruction at 0: only opcode and arg1 are accepted.
        fexp_q.push_back(8'h00);
        fexp_q.push_back(8'h01);
        push_instr(8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req),     32'(0));
        chk("rst_valid",   32'(instr_valid), 32'(0));
        chk("rst_en",      32'(en_in),       32'(0));
        chk("rst_pc",      32'(pc),          32'(0));
        chk("rst_a1",      32'(out_addr1),   32'(0));
        chk("rst_dst",     32'(in_addr),     32'(0));
        @(posedge clk) #1 rst = 1'b0;

        wait_instr(8, ok);
        if (ok) begin
            for (int i = 0; i < 20 && !(mem_req && mem_addr == 8'h01); i++) @(posedge clk) #1;
            chk("reach_a1", 32'(mem_addr), 32'(8'h01));
            @(posedge clk) #1;
            chk("abort_at_a2", 32'(mem_addr), 32'(8'h02));
            rst = 1'b1; force_valid = 1'b1;
            @(posedge clk) #1;
            rst = 1'b0; force_valid = 1'b0;
            @(negedge clk);
            chk("abort_pc",   32'(pc),        32'(0));
            chk("abort_a1",   32'(out_addr1), 32'(0));
            chk("abort_a2",   32'(out_addr2), 32'(0));
            chk("abort_dst",  32'(in_addr),   32'(0));
            chk("abort_addr", 32'(mem_addr),  32'(0));
            wait_instr(9, ok);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("fetch_q_empty", 32'(fexp_q.size()), 32'(0));
        chk("instr_q_empty", 32'(iexp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
